// File: rtl/imem_program_loader_if.sv
// imem_program_loader_if: byte-stream handshake plus instruction-memory write bus
interface imem_program_loader_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: boot-time byte-stream writer for instruction memory, holds the CPU in reset until loaded.
// Optional trailer checksum with ERROR state when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_program_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  imem_program_loader_if.slave bus,
  output logic                 cpu_rst_n,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      word_count
);
  typedef enum logic [2:0] {
    IDLE, HDR, LOAD, COMMIT, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK, ERROR
`endif
  } state_t;
  state_t                  state;
  logic [$clog2(DEPTH):0]  n;
  logic [1:0]              byte_cnt;
  logic [WORD_W-9:0]       shift;
  logic                    fire;
  logic                    restartable;
  assign fire = bus.in_valid && bus.in_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign restartable = state == IDLE || state == DONE || state == ERROR;
`else
  assign restartable = state == IDLE || state == DONE;
  assign err = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state          <= IDLE;
      n              <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rst_n      <= 1'b0;
      done           <= 1'b0;
      word_count     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err            <= 1'b0;
      csum           <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        HDR: if (fire) begin
          n     <= {1'b0, bus.in_data[ADDR_W-1:0]} + 1'b1;
          state <= LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum  <= bus.in_data;
`endif
        end
        LOAD: if (fire) begin
          shift    <= {shift[WORD_W-17:0], bus.in_data};
          byte_cnt <= byte_cnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= csum ^ bus.in_data;
`endif
          if (byte_cnt == 2'd3) begin
            state          <= COMMIT;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_count[ADDR_W-1:0];
            bus.imem_wdata <= {shift, bus.in_data};
          end
        end
        COMMIT: begin
          word_count <= word_count + 1'b1;
          if (word_count + 1'b1 == n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state        <= CHK;
            bus.in_ready <= 1'b1;
`else
            state        <= DONE;
            done         <= 1'b1;
            cpu_rst_n    <= 1'b1;
`endif
          end else begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: if (fire) begin
          bus.in_ready <= 1'b0;
          state        <= bus.in_data == csum ? DONE : ERROR;
          done         <= bus.in_data == csum;
          cpu_rst_n    <= bus.in_data == csum;
          err          <= bus.in_data != csum;
        end
`endif
        default: ;
      endcase
      if (start && restartable) begin
        state        <= HDR;
        bus.in_ready <= 1'b1;
        word_count   <= '0;
        byte_cnt     <= '0;
        cpu_rst_n    <= 1'b0;
        done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        err          <= 1'b0;
        csum         <= '0;
`endif
      end
    end
endmodule
